shift_load_ctrl: RTL and testbench

SHIFT_LOAD_CTRL -- requirements
Module: shift_load_ctrl

---
 rtl/shift_load_ctrl_pkg.sv | 16 +
 rtl/shift_load_ctrl_bit_counter.sv | 24 ++
 rtl/shift_load_ctrl.sv | 111 +++++++++++
 tb/tb_shift_load_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/shift_load_ctrl_pkg.sv
// Shared encodings for the shift-register load/rotate controller.
package shift_load_ctrl_pkg;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_ROR1 = 2'b01;
  localparam logic [1:0] SEL_ROR2 = 2'b10;
  localparam logic [1:0] SEL_SHIN = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    ROT  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/shift_load_ctrl_bit_counter.sv
// Counts LOAD cycles; tc_c flags the last of WIDTH cycles.
module bit_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0] cnt;

  assign tc_c = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cnt <= '0;
    else if (clr)      cnt <= '0;
    else if (en)       cnt <= tc_c ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/shift_load_ctrl.sv
// Serialises a word LSB-first into a multi-mode shift register, then rotates
// it right by the requested amount using 2-step and 1-step rotates.
module shift_load_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [RW-1:0]    rot,
  output logic [1:0]       sel,
  output logic             Sin,
  output logic             busy,
  output logic             done
);

  import shift_load_ctrl_pkg::*;

  state_t           state, state_d;
  logic [WIDTH-1:0] shadow, shadow_d;
  logic [RW-1:0]    rem, rem_d;
  logic             cnt_clr, cnt_en, tc_c;
  logic [1:0]       sel_d;
  logic             sin_d, busy_d, done_d, ready_d;

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc_c (tc_c)
  );

  // Next state and datapath; outputs are decoded from the next state so they
  // can be registered without adding a cycle of latency.
  always_comb begin
    state_d  = state;
    shadow_d = shadow;
    rem_d    = rem;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    sel_d    = SEL_HOLD;
    sin_d    = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    ready_d  = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          shadow_d = din;
          rem_d    = RW'(32'(rot) % WIDTH);
          cnt_clr  = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        shadow_d = shadow >> 1;
        cnt_en   = 1'b1;
        if (tc_c) state_d = (rem != '0) ? ROT : DONE;
      end
      ROT: begin
        if (32'(rem) >= 32'd2) rem_d = rem - RW'(2);
        else                   rem_d = '0;
        if (rem_d == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      IDLE: ready_d = 1'b1;
      LOAD: begin
        sel_d  = SEL_SHIN;
        sin_d  = shadow_d[0];
        busy_d = 1'b1;
      end
      ROT: begin
        sel_d  = (32'(rem_d) >= 32'd2) ? SEL_ROR2 : SEL_ROR1;
        busy_d = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shadow   <= '0;
      rem      <= '0;
      sel      <= SEL_HOLD;
      Sin      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_d;
      shadow   <= shadow_d;
      rem      <= rem_d;
      sel      <= sel_d;
      Sin      <= sin_d;
      busy     <= busy_d;
      done     <= done_d;
      in_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Bench for shift_load_ctrl driving an 8-bit multi-mode shift register.
module tb_shift_load_ctrl;
  import shift_load_ctrl_pkg::*;

  localparam int unsigned W = 8;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, Sin, busy, done;
  logic [7:0] din;
  logic [2:0] rot;
  logic [1:0] sel;
  logic [7:0] shreg = 8'h00;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_load_ctrl #(.WIDTH(8), .RW(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din      (din),
    .rot      (rot),
    .sel      (sel),
    .Sin      (Sin),
    .busy     (busy),
    .done     (done)
  );

  // Downstream multi-mode shift register
  always @(posedge clk) begin
    case (sel)
      2'b01:   shreg <= {shreg[0], shreg[7:1]};
      2'b10:   shreg <= {shreg[1:0], shreg[7:2]};
      2'b11:   shreg <= {Sin, shreg[7:1]};
      default: shreg <= shreg;
    endcase
  end

  typedef struct {
    logic [7:0] din;
    logic [2:0] rot;
    logic [7:0] exp_reg;
    int         exp_lat;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [7:0] ror8(input logic [7:0] v, input int n);
    logic [7:0] r = v;
    for (int i = 0; i < n; i++) r = {r[0], r[7:1]};
    return r;
  endfunction

  function automatic logic [5:0] ev(input logic [1:0] s, input logic sn,
                                    input logic b, input logic dn, input logic rdy);
    return {s, sn, b, dn, rdy};
  endfunction

  function automatic logic [5:0] obs();
    return {sel, Sin, busy, done, in_ready};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [7:0] d, input logic [2:0] r, input bit hold);
    @(negedge clk);
    in_valid = 1'b1;
    din      = d;
    rot      = r;
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    else begin
      din = 8'hFF;
      rot = 3'd2;
    end
  endtask

  // Expected per-cycle trace from accept until one idle cycle after done
  task automatic run_trace(input logic [7:0] d, input logic [2:0] r,
                           input logic [7:0] exp_reg, input int exp_lat);
    logic [5:0] q[$];
    int rr  = int'(r) % W;
    int lat = -1;
    int bc  = 0;
    for (int i = 0; i < W; i++) q.push_back(ev(SEL_SHIN, d[i], 1'b1, 1'b0, 1'b0));
    while (rr >= 2) begin
      q.push_back(ev(SEL_ROR2, 1'b0, 1'b1, 1'b0, 1'b0));
      rr -= 2;
    end
    if (rr == 1) q.push_back(ev(SEL_ROR1, 1'b0, 1'b1, 1'b0, 1'b0));
    q.push_back(ev(SEL_HOLD, 1'b0, 1'b0, 1'b1, 1'b0));
    q.push_back(ev(SEL_HOLD, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      chk($sformatf("trace din=%h rot=%0d cyc=%0d", d, r, i), 32'(obs()), 32'(q[i]));
      if (done === 1'b1 && lat < 0) begin
        lat = i;
        chk($sformatf("result din=%h rot=%0d", d, r), 32'(shreg), 32'(exp_reg));
      end
      if (busy === 1'b1) bc++;
    end
    chk($sformatf("latency din=%h rot=%0d", d, r), lat, exp_lat);
    chk($sformatf("busy_cycles din=%h rot=%0d", d, r), bc, exp_lat);
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    din      = 8'h00;
    rot      = 3'd0;

    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(obs()), 32'(ev(SEL_HOLD, 1'b0, 1'b0, 1'b0, 1'b1)));
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'(obs()), 32'(ev(SEL_HOLD, 1'b0, 1'b0, 1'b0, 1'b1)));

    tbl.push_back('{8'hA5, 3'd0, 8'hA5, 8});
    tbl.push_back('{8'h81, 3'd3, 8'h30, 10});
    tbl.push_back('{8'h01, 3'd7, 8'h02, 12});
    tbl.push_back('{8'h3C, 3'd1, 8'h1E, 9});
    tbl.push_back('{8'hF0, 3'd2, 8'h3C, 9});
    tbl.push_back('{8'h96, 3'd6, 8'h5A, 11});
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v.din     = 8'($urandom_range(0, 255));
      v.rot     = 3'($urandom_range(0, 7));
      v.exp_reg = ror8(v.din, int'(v.rot));
      v.exp_lat = W + (int'(v.rot) + 1) / 2;
      tbl.push_back(v);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i].din, tbl[i].rot, 1'b0);
      run_trace(tbl[i].din, tbl[i].rot, tbl[i].exp_reg, tbl[i].exp_lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // in_valid held high with a different word across a running request
    issue(8'h81, 3'd3, 1'b1);
    run_trace(8'h81, 3'd3, 8'h30, 10);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    run_trace(8'hFF, 3'd2, 8'hFF, 9);
    @(negedge clk);
    chk("no_extra_accept", 32'(obs()), 32'(ev(SEL_HOLD, 1'b0, 1'b0, 1'b0, 1'b1)));

    // Reset asserted on the 4th LOAD cycle
    issue(8'h5A, 3'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d = 8'h5A;
      @(negedge clk);
      chk($sformatf("pre_abort cyc=%0d", i), 32'(obs()),
          32'(ev(SEL_SHIN, d[i], 1'b1, 1'b0, 1'b0)));
    end
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset", 32'(obs()), 32'(ev(SEL_HOLD, 1'b0, 1'b0, 1'b0, 1'b1)));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset_held cyc=%0d", i), 32'(obs()),
          32'(ev(SEL_HOLD, 1'b0, 1'b0, 1'b0, 1'b1)));
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("after_abort cyc=%0d", i), 32'(obs()),
          32'(ev(SEL_HOLD, 1'b0, 1'b0, 1'b0, 1'b1)));
    end
    issue(8'h3C, 3'd1, 1'b0);
    run_trace(8'h3C, 3'd1, 8'h1E, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
